multiplier_12bit: RTL and testbench

- Iterative unsigned 12x12 multiplier that produces a 24-bit registered product.
- Free-running: it samples both operands, computes with a radix-2 shift-add over 12 iterations, updates `result`, then immediately samples again.
- Used as a compact, area-optimized mantissa multiplier for the FPU datapath.
- No handshake; consumers hold operands stable for at least one full period or tolerate one-period lag.

---
 rtl/multiplier_12bit.sv | 91 +++++++++
 tb/tb_multiplier_12bit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/multiplier_12bit.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier; one new product every WIDTH+1 clocks.
// Define MULTIPLIER_VALID_EN to add a one-cycle result_valid strobe alongside each result update.
module multiplier_12bit #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
`ifdef MULTIPLIER_VALID_EN
  output logic                 result_valid,
`endif
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     m_reg, m_next;
  logic [2*WIDTH:0]     p_reg, p_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic                 done;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum_hi;
  logic [2*WIDTH:0]     p_shift;

  // Multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = m_reg[gi] & p_reg[0];
    end
  endgenerate

  // The upper half never exceeds WIDTH bits before the add, so WIDTH+1 bits hold the carry.
  assign sum_hi  = p_reg[2*WIDTH:WIDTH] + {1'b0, addend};
  assign p_shift = {1'b0, sum_hi, p_reg[WIDTH-1:1]};
  assign done    = (cnt_reg == LAST);

  always_comb begin
    cnt_next    = cnt_reg;
    m_next      = m_reg;
    p_next      = p_reg;
    result_next = result_reg;
    if (cnt_reg == '0) begin
      m_next   = num1;
      p_next   = {{(WIDTH + 1){1'b0}}, num2};
      cnt_next = CW'(1);
    end else begin
      p_next = p_shift;
      if (done) begin
        result_next = p_shift[2*WIDTH-1:0];
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_reg    <= '0;
      m_reg      <= '0;
      p_reg      <= '0;
      result_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      m_reg      <= m_next;
      p_reg      <= p_next;
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

`ifdef MULTIPLIER_VALID_EN
  logic result_valid_reg;

  always_ff @(posedge clk) begin
    if (rstn) begin
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= done;
    end
  end

  assign result_valid = result_valid_reg;
`endif

endmodule

// File: tb/tb_multiplier_12bit.sv
// Directed bench for multiplier_12bit: reset, timing of each 13-cycle period, operand sampling and mid-run reset.
module tb_multiplier_12bit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] num1;
  logic [11:0] num2;
  logic [23:0] result;
`ifdef MULTIPLIER_VALID_EN
  logic        result_valid;
`endif

  int errors = 0;
  int checks = 0;

  multiplier_12bit #(.WIDTH(12)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .num1         (num1),
    .num2         (num2),
`ifdef MULTIPLIER_VALID_EN
    .result_valid (result_valid),
`endif
    .result       (result)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%06h expected=%06h", tag, obs, exp);
    end
    $display("check %-14s result=%06h expected=%06h", tag, obs, exp);
  endtask

  task automatic check_valid(input string tag, input logic exp);
`ifdef MULTIPLIER_VALID_EN
    check(tag, {23'd0, result_valid}, {23'd0, exp});
`endif
  endtask

  // From just after an update edge: load new operands and expect the product 13 edges later.
  task automatic product(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [23:0] prev, input logic [23:0] exp);
    num1 = a;
    num2 = b;
    tick(12);
    check({tag, "_hold"}, result, prev);
    check_valid({tag, "_vlo"}, 1'b0);
    tick(1);
    check(tag, result, exp);
    check_valid({tag, "_vhi"}, 1'b1);
  endtask

  initial begin
    rstn = 1'b1;
    num1 = 12'h123;
    num2 = 12'h456;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset", result, 24'h000000);
      check_valid("reset_v", 1'b0);
    end

    // First period after release: LOAD on first edge, update on the 13th.
    num1 = 12'hAB2;
    num2 = 12'hC71;
    rstn = 1'b0;
    tick(12);
    check("first_hold", result, 24'h000000);
    tick(1);
    check("first", result, 24'h851092);
    check_valid("first_v", 1'b1);
    tick(1);
    check("after_load", result, 24'h851092);
    check_valid("after_load_v", 1'b0);
    tick(12);
    check("repeat", result, 24'h851092);
    check_valid("repeat_v", 1'b1);

    product("max", 12'hFFF, 12'hFFF, 24'h851092, 24'hFFE001);
    product("zero", 12'h000, 12'hFFF, 24'hFFE001, 24'h000000);

    // Operand change during ITERATE must not disturb the product in flight.
    num1 = 12'h001;
    num2 = 12'h9A5;
    tick(4);
    num2 = 12'h002;
    tick(8);
    check("inflight_hold", result, 24'h000000);
    tick(1);
    check("inflight", result, 24'h0009A5);
    tick(13);
    check("next_period", result, 24'h000002);

    product("msb", 12'h800, 12'h800, 24'h000002, 24'h400000);
    product("ones", 12'hFFF, 12'h001, 24'h400000, 24'h000FFF);
    product("alt", 12'h555, 12'hAAA, 24'h000FFF, 24'h38DC72);

    // Reset while cnt==6 aborts the computation and clears result.
    num1 = 12'h0C8;
    num2 = 12'h064;
    tick(6);
    rstn = 1'b1;
    tick(1);
    check("midreset", result, 24'h000000);
    check_valid("midreset_v", 1'b0);
    rstn = 1'b0;
    tick(12);
    check("restart_hold", result, 24'h000000);
    check_valid("restart_vlo", 1'b0);
    tick(1);
    check("restart", result, 24'h004E20);
    check_valid("restart_v", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
